bytemask_gen: RTL and testbench

- Parametrised successor to the fixed 16-lane SRAM byte-mask decoder.
- Accepts write requests (start lane offset, length, target port, merge flag) over a valid/ready handshake.
- Emits active-low byte masks for SRAM port A or B, either one lane per beat or all lanes merged into a single beat.
- Sits between the address/offset controller and the dual-port SRAM write interface.

---
 rtl/bytemask_gen.sv | 208 ++++++++++++++++++++
 tb/tb_bytemask_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bytemask_gen.sv
// bytemask_gen: active-low SRAM byte-mask generator for a dual-port write path.
// Accepts (offset, len, port, merge) requests over valid/ready and emits
// either one single-lane mask per beat (burst) or one merged mask (merge).
// Ports:
//   clk, rst           clock, async active-high reset
//   req_valid/ready    request handshake
//   req_offset [LW]    starting lane, req_len [LW+1] lane count (0 = LANES)
//   req_port           0 = port A, 1 = port B
//   req_merge          1 = one merged beat, 0 = one lane per beat
//   out_ready          SRAM side accepts the current beat
//   mask_valid_a/b     beat valid per port
//   sram_bytemask_a/b  active-low masks (0 = write byte)
// Optional: define BYTEMASK_GEN_STAT_EN to add stat_clr / stat_beats.
// MAP_MODE=1 (tile interleave) is only meaningful with LANES=16.
module bytemask_gen #(
    parameter int  LANES    = 16,
    parameter int  MAP_MODE = 1,
    localparam int LW       = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LW-1:0]    req_offset,
    input  logic [LW:0]      req_len,
    input  logic             req_port,
    input  logic             req_merge,
    input  logic             out_ready,
    output logic             mask_valid_a,
    output logic             mask_valid_b,
    output logic [LANES-1:0] sram_bytemask_a,
    output logic [LANES-1:0] sram_bytemask_b
`ifdef BYTEMASK_GEN_STAT_EN
    ,
    input  logic             stat_clr,
    output logic [15:0]      stat_beats
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MERGE,
        S_BURST
    } state_t;

    state_t            r_state;
    logic [LW-1:0]     r_off;
    logic [LW:0]       r_rem;
    logic              r_port;
    logic              r_ready;
    logic              r_valid_a;
    logic              r_valid_b;
    logic [LANES-1:0]  r_mask_a;
    logic [LANES-1:0]  r_mask_b;

    logic [LW-1:0]     w_off_nxt;
    logic [LW:0]       w_len_eff;
    logic [LANES-1:0]  w_first_mask;
    logic [LANES-1:0]  w_step_mask;

    // Single-lane mask: lane k clears exactly one bit chosen by the map.
    function automatic logic [LANES-1:0] lane_mask(input logic [LW-1:0] k);
        logic [LANES-1:0] m;
        int               b;
        m = '1;
        if (MAP_MODE == 0) begin
            b = LANES - 1 - int'(k);
        end else begin
            case (int'(k))
                0:       b = 15;
                1:       b = 11;
                2:       b = 14;
                3:       b = 10;
                4:       b = 7;
                5:       b = 3;
                6:       b = 6;
                7:       b = 2;
                8:       b = 13;
                9:       b = 9;
                10:      b = 12;
                11:      b = 8;
                12:      b = 5;
                13:      b = 1;
                14:      b = 4;
                default: b = 0;
            endcase
        end
        for (int i = 0; i < LANES; i++) begin
            if (i == b) m[i] = 1'b0;
        end
        return m;
    endfunction

    // Merged mask: AND of lanes off..off+n-1; the LW-bit add wraps mod LANES.
    function automatic logic [LANES-1:0] merge_mask(
        input logic [LW-1:0] off,
        input logic [LW:0]   len
    );
        logic [LANES-1:0] m;
        int               n;
        m = '1;
        n = (len == '0) ? LANES : int'(len);
        for (int i = 0; i < LANES; i++) begin
            if (i < n) m &= lane_mask(off + LW'(i));
        end
        return m;
    endfunction

    always_comb begin
        w_off_nxt    = r_off + LW'(1);
        w_len_eff    = (req_len == '0) ? (LW+1)'(LANES) : req_len;
        w_first_mask = req_merge ? merge_mask(req_offset, req_len)
                                 : lane_mask(req_offset);
        w_step_mask  = lane_mask(w_off_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_off     <= '0;
            r_rem     <= '0;
            r_port    <= 1'b0;
            r_ready   <= 1'b1;
            r_valid_a <= 1'b0;
            r_valid_b <= 1'b0;
            r_mask_a  <= '1;
            r_mask_b  <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_off   <= req_offset;
                        r_rem   <= w_len_eff;
                        r_port  <= req_port;
                        r_ready <= 1'b0;
                        r_state <= req_merge ? S_MERGE : S_BURST;
                        if (req_port) begin
                            r_valid_b <= 1'b1;
                            r_mask_b  <= w_first_mask;
                        end else begin
                            r_valid_a <= 1'b1;
                            r_mask_a  <= w_first_mask;
                        end
                    end
                end
                S_MERGE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        r_ready   <= 1'b1;
                        r_valid_a <= 1'b0;
                        r_valid_b <= 1'b0;
                        r_mask_a  <= '1;
                        r_mask_b  <= '1;
                    end
                end
                S_BURST: begin
                    if (out_ready) begin
                        r_off <= w_off_nxt;
                        r_rem <= r_rem - (LW+1)'(1);
                        if (r_rem == (LW+1)'(1)) begin
                            r_state   <= S_IDLE;
                            r_ready   <= 1'b1;
                            r_valid_a <= 1'b0;
                            r_valid_b <= 1'b0;
                            r_mask_a  <= '1;
                            r_mask_b  <= '1;
                        end else if (r_port) begin
                            r_mask_b <= w_step_mask;
                        end else begin
                            r_mask_a <= w_step_mask;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = r_ready;
    assign mask_valid_a    = r_valid_a;
    assign mask_valid_b    = r_valid_b;
    assign sram_bytemask_a = r_mask_a;
    assign sram_bytemask_b = r_mask_b;

`ifdef BYTEMASK_GEN_STAT_EN
    logic        w_beat;
    logic [15:0] r_stat;

    assign w_beat = (r_valid_a | r_valid_b) & out_ready;

    // Saturating beat counter; a clear beats a concurrent increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat <= '0;
        end else if (stat_clr) begin
            r_stat <= '0;
        end else if (w_beat && (r_stat != 16'hFFFF)) begin
            r_stat <= r_stat + 16'd1;
        end
    end

    assign stat_beats = r_stat;
`endif

endmodule

// File: tb/tb_bytemask_gen.sv
// tb_bytemask_gen: table-driven scoreboard bench for bytemask_gen.
// Two instances (MAP_MODE 0 and 1) share stimulus; each vector picks one.
module tb_bytemask_gen;

    typedef struct packed {
        logic             sel;
        logic [3:0]       off;
        logic [4:0]       len;
        logic             port;
        logic             merge;
        logic [2:0]       nb;
        logic [3:0][15:0] m;
        logic [2:0]       sb;
        logic [2:0]       sn;
    } vec_t;

    typedef struct packed {
        logic        port;
        logic [15:0] mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_offset;
    logic [4:0]  req_len;
    logic        req_port;
    logic        req_merge;
    logic        out_ready;
    logic        rdy0, rdy1;
    logic        va0, vb0, va1, vb1;
    logic [15:0] ma0, mb0, ma1, mb1;
    logic        cur_sel;
    logic        s_rdy, s_va, s_vb;
    logic [15:0] s_ma, s_mb;
`ifdef BYTEMASK_GEN_STAT_EN
    logic        stat_clr;
    logic [15:0] stat0, stat1;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    bytemask_gen #(.LANES(16), .MAP_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy0),
        .req_offset(req_offset), .req_len(req_len),
        .req_port(req_port), .req_merge(req_merge),
        .out_ready(out_ready),
        .mask_valid_a(va0), .mask_valid_b(vb0),
        .sram_bytemask_a(ma0), .sram_bytemask_b(mb0)
`ifdef BYTEMASK_GEN_STAT_EN
        , .stat_clr(stat_clr), .stat_beats(stat0)
`endif
    );

    bytemask_gen #(.LANES(16), .MAP_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy1),
        .req_offset(req_offset), .req_len(req_len),
        .req_port(req_port), .req_merge(req_merge),
        .out_ready(out_ready),
        .mask_valid_a(va1), .mask_valid_b(vb1),
        .sram_bytemask_a(ma1), .sram_bytemask_b(mb1)
`ifdef BYTEMASK_GEN_STAT_EN
        , .stat_clr(stat_clr), .stat_beats(stat1)
`endif
    );

    assign s_rdy = cur_sel ? rdy1 : rdy0;
    assign s_va  = cur_sel ? va1  : va0;
    assign s_vb  = cur_sel ? vb1  : vb0;
    assign s_ma  = cur_sel ? ma1  : ma0;
    assign s_mb  = cur_sel ? mb1  : mb0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic sel, input logic [3:0] off, input logic [4:0] len,
        input logic port, input logic merge, input logic [2:0] nb,
        input logic [15:0] a, input logic [15:0] b,
        input logic [15:0] c, input logic [15:0] d,
        input logic [2:0] sb, input logic [2:0] sn);
        vec_t v;
        v.sel = sel; v.off = off; v.len = len; v.port = port;
        v.merge = merge; v.nb = nb; v.m = {d, c, b, a};
        v.sb = sb; v.sn = sn;
        return v;
    endfunction

    task automatic chk_idle(input string nm);
        chk({nm, "_valid"}, {30'd0, s_va, s_vb}, 32'd0);
        chk({nm, "_mask_a"}, {16'd0, s_ma}, 32'h0000FFFF);
        chk({nm, "_mask_b"}, {16'd0, s_mb}, 32'h0000FFFF);
        chk({nm, "_ready"}, {31'd0, s_rdy}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cyc;
        int   stall;
        int   bi;
        cur_sel = v.sel;
        for (int i = 0; i < int'(v.nb); i++) begin
            e.port = v.port;
            e.mask = v.m[i];
            sbq.push_back(e);
        end
        @(negedge clk);
        chk("pre_ready", {31'd0, s_rdy}, 32'd1);
        req_valid  = 1'b1;
        req_offset = v.off;
        req_len    = v.len;
        req_port   = v.port;
        req_merge  = v.merge;
        out_ready  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        stall = int'(v.sn);
        bi = 0;
        cyc = 0;
        while (sbq.size() != 0 && cyc < 64) begin
            if (s_va || s_vb) begin
                e = sbq[0];
                chk("beat_port", {30'd0, s_va, s_vb},
                    e.port ? 32'd1 : 32'd2);
                chk("beat_mask", {16'd0, e.port ? s_mb : s_ma},
                    {16'd0, e.mask});
                chk("other_mask", {16'd0, e.port ? s_ma : s_mb},
                    32'h0000FFFF);
                chk("busy_ready", {31'd0, s_rdy}, 32'd0);
                if (bi == int'(v.sb) && stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else begin
                    out_ready = 1'b1;
                    void'(sbq.pop_front());
                    bi++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        if (sbq.size() != 0) begin
            chk("beat_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
        chk_idle("end");
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_offset = '0;
        req_len    = '0;
        req_port   = 1'b0;
        req_merge  = 1'b0;
        out_ready  = 1'b1;
        cur_sel    = 1'b1;
`ifdef BYTEMASK_GEN_STAT_EN
        stat_clr   = 1'b0;
`endif
        tbl[0] = mk(1, 5,  1, 0, 0, 1, 16'hFFF7, 0, 0, 0, 7, 0);
        tbl[1] = mk(0, 14, 4, 1, 0, 4, 16'hFFFD, 16'hFFFE,
                    16'h7FFF, 16'hBFFF, 7, 0);
        tbl[2] = mk(1, 0,  4, 0, 1, 1, 16'h33FF, 0, 0, 0, 7, 0);
        tbl[3] = mk(1, 0,  0, 0, 1, 1, 16'h0000, 0, 0, 0, 7, 0);
        tbl[4] = mk(1, 12, 4, 1, 0, 4, 16'hFFDF, 16'hFFFD,
                    16'hFFEF, 16'hFFFE, 1, 3);
        tbl[5] = mk(0, 15, 2, 0, 1, 1, 16'h7FFE, 0, 0, 0, 7, 0);
        tbl[6] = mk(1, 8,  3, 0, 1, 1, 16'hCDFF, 0, 0, 0, 7, 0);
        tbl[7] = mk(0, 4,  8, 1, 1, 1, 16'hF00F, 0, 0, 0, 7, 0);
        tbl[8] = mk(0, 0,  1, 0, 0, 1, 16'h7FFF, 0, 0, 0, 7, 0);

        repeat (2) @(negedge clk);
        chk_idle("rst1");
        cur_sel = 1'b0;
        chk_idle("rst0");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

        // reset mid-burst: second beat is visible, then async reset
        cur_sel = 1'b1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_offset = 4'd12;
        req_len    = 5'd4;
        req_port   = 1'b1;
        req_merge  = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rb_beat1", {16'd0, s_mb}, 32'h0000FFDF);
        @(negedge clk);
        chk("rb_beat2", {16'd0, s_mb}, 32'h0000FFFD);
        #1 rst = 1'b1;
        #1;
        chk_idle("rb_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rb_no_beat", {30'd0, s_va, s_vb}, 32'd0);
        end
        chk_idle("rb_after");

`ifdef BYTEMASK_GEN_STAT_EN
        chk("stat_rst", {16'd0, stat1}, 32'd0);
        run_vec(tbl[0]);
        run_vec(tbl[1]);
        run_vec(tbl[2]);
        chk("stat_six", {16'd0, stat0}, 32'd6);
        chk("stat_six1", {16'd0, stat1}, 32'd6);
        cur_sel = 1'b1;
        req_valid  = 1'b1;
        req_offset = 4'd5;
        req_len    = 5'd1;
        req_port   = 1'b0;
        req_merge  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("stat_beat", {16'd0, s_ma}, 32'h0000FFF7);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_clr", {16'd0, stat1}, 32'd0);
        chk_idle("stat_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
